// File: rtl/proc_0_cpu_mult_pkg.sv
// Shared definitions for the CPU multiplier combine stage.
// Holds op encodings, the FSM state type, the half-word width and the
// iteration-count helper used by the combine top and the hi*hi iterator.
package proc_0_cpu_mult_pkg;

  localparam int HALF_W = 16;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Number of hi*hi loop cycles for a given multiplier-bits-per-cycle.
  function automatic int iter_count(input int bits_per_iter);
    return HALF_W / bits_per_iter;
  endfunction

endpackage

// File: rtl/proc_0_cpu_mult_iter.sv
// Iterative 16x16 unsigned shift-add multiplier for the hi*hi partial.
// Ports: clk/reset, start_i loads operands, abort_i stops the loop,
//        a_i/b_i 16-bit operands, acc_o 32-bit product, done_o on last step.
// Latency: iter_count(BITS_PER_ITER) cycles after start_i; no backpressure.
module proc_0_cpu_mult_iter
  import proc_0_cpu_mult_pkg::*;
#(
  parameter int BITS_PER_ITER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output logic [31:0]       acc_o,
  output logic              done_o
);

  localparam int         N    = iter_count(BITS_PER_ITER);
  localparam logic [3:0] LAST = 4'(N - 1);

  logic              run_q, run_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       mcand_q, mcand_d;
  logic [HALF_W-1:0] mplier_q, mplier_d;
  logic [31:0]       pp;

  // Multiplicand is pre-shifted each step, so the partial product needs no
  // variable shifter: just the low BITS_PER_ITER multiplier bits times it.
  always_comb begin
    pp       = mcand_q * 32'(mplier_q[BITS_PER_ITER-1:0]);
    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      run_d    = 1'b1;
      cnt_d    = 4'd0;
      acc_d    = 32'd0;
      mcand_d  = {16'd0, a_i};
      mplier_d = b_i;
    end else if (abort_i) begin
      run_d = 1'b0;
    end else if (run_q) begin
      acc_d    = acc_q + pp;
      mcand_d  = mcand_q << BITS_PER_ITER;
      mplier_d = mplier_q >> BITS_PER_ITER;
      cnt_d    = cnt_q + 4'd1;
      if (cnt_q == LAST) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      cnt_q    <= 4'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = run_q && (cnt_q == LAST);

endmodule

// File: rtl/proc_0_cpu_mult_combine.sv
// Combines mult-cell partial products into the Nios II MUL/MULX* result.
// Ports: M-stage op/operands/partials in; mul_result, one-cycle
//        mul_result_valid and mul_busy (pipeline stall) out.
// Latency: MUL 1 cycle, MULX* N+2 cycles; mul_busy stalls the pipe meanwhile.
module proc_0_cpu_mult_combine
  import proc_0_cpu_mult_pkg::*;
#(
  parameter int BITS_PER_ITER = 1,
  parameter int DATA_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              M_en,
  input  logic              M_start,
  input  logic [1:0]        M_op,
  input  logic [DATA_W-1:0] M_src1,
  input  logic [DATA_W-1:0] M_src2,
  input  logic [DATA_W-1:0] M_mul_cell_p1,
  input  logic [DATA_W-1:0] M_mul_cell_p2,
  input  logic [DATA_W-1:0] M_mul_cell_p3,
  input  logic              M_flush,
  output logic [DATA_W-1:0] mul_result,
  output logic              mul_result_valid,
  output logic              mul_busy
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [HALF_W:0]   mid_hi_q, mid_hi_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              valid_q, valid_d;

  logic [DATA_W:0]   mid, lo_sum;
  logic [DATA_W-1:0] hi_fix;
  logic [31:0]       p4;
  logic              iter_done, accept, start_x;

  assign accept  = M_start && M_en && (state_q == ST_IDLE) && !M_flush;
  assign start_x = accept && (M_op != OP_MUL);

  proc_0_cpu_mult_iter #(.BITS_PER_ITER(BITS_PER_ITER)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_x),
    .abort_i (M_flush),
    .a_i     (M_src1[DATA_W-1:HALF_W]),
    .b_i     (M_src2[DATA_W-1:HALF_W]),
    .acc_o   (p4),
    .done_o  (iter_done)
  );

  always_comb begin
    mid    = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
    lo_sum = {1'b0, M_mul_cell_p1} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};

    // Unsigned high word, then remove the 2^32 * sign * other-operand terms
    // that a two's-complement interpretation of A and/or B adds.
    hi_fix = p4 + {15'd0, mid_hi_q} + {31'd0, c_q};
    if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[DATA_W-1]) hi_fix = hi_fix - b_q;
    if ((op_q == OP_MULXSS) && b_q[DATA_W-1]) hi_fix = hi_fix - a_q;

    state_d  = state_q;
    op_d     = op_q;
    mid_hi_d = mid_hi_q;
    c_d      = c_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (M_op == OP_MUL) begin
            result_d = lo_sum[DATA_W-1:0];
            valid_d  = 1'b1;
          end else begin
            state_d  = ST_ITER;
            op_d     = M_op;
            mid_hi_d = mid[DATA_W:HALF_W];
            c_d      = lo_sum[DATA_W];
            a_d      = M_src1;
            b_d      = M_src2;
          end
        end
      end
      ST_ITER: begin
        if (M_flush)        state_d = ST_IDLE;
        else if (iter_done) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!M_flush) begin
          result_d = hi_fix;
          valid_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      mid_hi_q <= '0;
      c_q      <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mid_hi_q <= mid_hi_d;
      c_q      <= c_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign mul_result       = result_q;
  assign mul_result_valid = valid_q;
  assign mul_busy         = (state_q != ST_IDLE);

endmodule
